// File: rtl/rxif_byte_packer.sv
// Byte-to-word ingress packer: packs a MAC byte stream little-endian into 32-bit
// AXI-Stream beats with first/error/byte-count sideband and a maximum frame length.
module rxif_byte_packer #(
  parameter int unsigned MAX_BYTES = 1522
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mac_rx_tvalid_i,
  output logic        mac_rx_tready_o,
  input  logic [7:0]  mac_rx_tdata_i,
  input  logic        mac_rx_tlast_i,
  input  logic        mac_rx_tuser_i,
  output logic        rxif_fifo_tvalid_o,
  input  logic        rxif_fifo_tready_i,
  output logic [31:0] rxif_fifo_tdata_o,
  output logic        rxif_fifo_tlast_o,
  output logic [3:0]  rxif_fifo_tuser_o
);

  typedef enum logic [1:0] {IDLE, FILL, DROP} state_t;

  localparam logic [15:0] MaxCnt = 16'(MAX_BYTES);

  state_t      state_q, state_d;
  logic [23:0] hold_q, hold_d;
  logic [1:0]  lane_q, lane_d;
  logic        first_q, first_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        tvalid_q, tvalid_d;
  logic [31:0] tdata_q, tdata_d;
  logic        tlast_q, tlast_d;
  logic [3:0]  tuser_q, tuser_d;

  logic        ready;
  logic        accept;
  logic        at_max;
  logic        complete;
  logic        err_now;
  logic [15:0] cnt_inc;
  logic [31:0] word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      lane_q   <= '0;
      first_q  <= 1'b1;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      lane_q   <= lane_d;
      first_q  <= first_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
    end
  end

  // The holding register is cleared whenever a beat is emitted, so the lanes at and
  // above the current lane are always zero and a plain OR places the new byte.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    lane_d   = lane_q;
    first_d  = first_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;

    ready    = (state_q == DROP) || !tvalid_q || rxif_fifo_tready_i;
    accept   = mac_rx_tvalid_i && ready;
    cnt_inc  = cnt_q + 16'd1;
    at_max   = (cnt_inc == MaxCnt);
    err_now  = err_q | mac_rx_tuser_i;
    complete = (lane_q == 2'd3) || mac_rx_tlast_i || at_max;
    word     = {8'h00, hold_q} | ({24'h000000, mac_rx_tdata_i} << {lane_q, 3'b000});

    if (tvalid_q && rxif_fifo_tready_i) begin
      tvalid_d = 1'b0;
    end

    if (accept) begin
      if (state_q == DROP) begin
        if (mac_rx_tlast_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b0;
          first_d = 1'b1;
          lane_d  = '0;
          hold_d  = '0;
        end
      end else begin
        if (complete) begin
          tvalid_d = 1'b1;
          tdata_d  = word;
          tlast_d  = mac_rx_tlast_i | at_max;
          tuser_d  = {first_q, err_now | (at_max & ~mac_rx_tlast_i), lane_q};
          lane_d   = '0;
          first_d  = 1'b0;
          hold_d   = '0;
        end else begin
          hold_d = word[23:0];
          lane_d = lane_q + 2'd1;
        end

        // A frame ending exactly at the limit is a normal end; otherwise truncate.
        if (mac_rx_tlast_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b0;
          first_d = 1'b1;
        end else if (at_max) begin
          state_d = DROP;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else begin
          state_d = FILL;
          cnt_d   = cnt_inc;
          err_d   = err_now;
        end
      end
    end
  end

  assign mac_rx_tready_o    = ready;
  assign rxif_fifo_tvalid_o = tvalid_q;
  assign rxif_fifo_tdata_o  = tdata_q;
  assign rxif_fifo_tlast_o  = tlast_q;
  assign rxif_fifo_tuser_o  = tuser_q;

endmodule

// File: tb/tb_rxif_byte_packer.sv
// Directed and randomised bench for rxif_byte_packer; a second instance with an
// 8-byte limit exercises truncation.
module tb_rxif_byte_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        macValid, macLast, macUser;
  logic [7:0]  macData;
  logic        fifoReady;
  logic        ready, fifoValid, fifoLast;
  logic [31:0] fifoData;
  logic [3:0]  fifoUser;
  logic        readyMax, fifoValidMax, fifoLastMax;
  logic [31:0] fifoDataMax;
  logic [3:0]  fifoUserMax;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [3:0]  u;
  } beat_t;

  beat_t gotQ[$];
  beat_t gotMaxQ[$];
  beat_t expQ[$];
  beat_t held;
  bit    heldValid  = 1'b0;
  int    holdErrors = 0;
  bit    randReady  = 1'b0;
  int    checks     = 0;
  int    failures   = 0;

  rxif_byte_packer dut (
    .clk(clk), .rst(rst),
    .mac_rx_tvalid_i(macValid), .mac_rx_tready_o(ready), .mac_rx_tdata_i(macData),
    .mac_rx_tlast_i(macLast), .mac_rx_tuser_i(macUser),
    .rxif_fifo_tvalid_o(fifoValid), .rxif_fifo_tready_i(fifoReady),
    .rxif_fifo_tdata_o(fifoData), .rxif_fifo_tlast_o(fifoLast), .rxif_fifo_tuser_o(fifoUser)
  );

  rxif_byte_packer #(.MAX_BYTES(8)) dutMax (
    .clk(clk), .rst(rst),
    .mac_rx_tvalid_i(macValid), .mac_rx_tready_o(readyMax), .mac_rx_tdata_i(macData),
    .mac_rx_tlast_i(macLast), .mac_rx_tuser_i(macUser),
    .rxif_fifo_tvalid_o(fifoValidMax), .rxif_fifo_tready_i(fifoReady),
    .rxif_fifo_tdata_o(fifoDataMax), .rxif_fifo_tlast_o(fifoLastMax), .rxif_fifo_tuser_o(fifoUserMax)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so a valid&&ready seen here completes at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      heldValid = 1'b0;
    end else begin
      if (heldValid && (!fifoValid || {fifoData, fifoLast, fifoUser} != held)) holdErrors++;
      if (fifoValid && fifoReady) gotQ.push_back({fifoData, fifoLast, fifoUser});
      if (fifoValidMax && fifoReady) gotMaxQ.push_back({fifoDataMax, fifoLastMax, fifoUserMax});
      heldValid = fifoValid && !fifoReady;
      held      = {fifoData, fifoLast, fifoUser};
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog simulation time limit reached, required run to finish earlier");
    $fatal(1, "[TB] watchdog");
  end

  task automatic sendByte(input logic [7:0] d, input logic l, input logic u);
    int spins = 0;
    bit acc;
    macValid = 1'b1;
    macData  = d;
    macLast  = l;
    macUser  = u;
    forever begin
      if (randReady) fifoReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = ready;
      @(posedge clk);
      #1;
      if (acc) break;
      spins++;
      if (spins > 500) begin
        checks++;
        failures++;
        $display("[TB] FAIL accept_timeout byte %h ready=%b, required 1 within 500 cycles", d, ready);
        break;
      end
    end
    macValid = 1'b0;
    macLast  = 1'b0;
    macUser  = 1'b0;
  endtask

  task automatic sendSeq(input logic [7:0] start, input int n, input int errIdx);
    for (int i = 0; i < n; i++) sendByte(start + 8'(i), i == n - 1, i == errIdx);
  endtask

  task automatic drain();
    randReady = 1'b0;
    fifoReady = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic clearQueues();
    gotQ.delete();
    gotMaxQ.delete();
    expQ.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    macValid = 1'b0; macData = '0; macLast = 1'b0; macUser = 1'b0;
    fifoReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (fifoValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_tvalid got %b expected 0", fifoValid); end
    checks++; if (fifoData !== 32'h0) begin failures++; $display("[TB] FAIL reset_tdata got %h expected 0", fifoData); end
    checks++; if (fifoLast !== 1'b0) begin failures++; $display("[TB] FAIL reset_tlast got %b expected 0", fifoLast); end
    checks++; if (fifoUser !== 4'h0) begin failures++; $display("[TB] FAIL reset_tuser got %b expected 0000", fifoUser); end
    checks++; if (ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_tready got %b expected 1", ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    clearQueues();
    sendSeq(8'h01, 8, -1);
    drain();
    expQ.push_back({32'h04030201, 1'b0, 4'b1011});
    expQ.push_back({32'h08070605, 1'b1, 4'b0011});
    checks++;
    if (gotQ.size() != expQ.size()) begin
      failures++; $display("[TB] FAIL basic_count got %0d beats expected %0d", gotQ.size(), expQ.size());
    end else begin
      for (int i = 0; i < expQ.size(); i++) begin
        checks++;
        if (gotQ[i] !== expQ[i]) begin
          failures++;
          $display("[TB] FAIL basic_beat%0d got %h/%b/%b expected %h/%b/%b", i, gotQ[i].d, gotQ[i].l, gotQ[i].u, expQ[i].d, expQ[i].l, expQ[i].u);
        end
      end
    end
  endtask

  task automatic test_error();
    clearQueues();
    sendSeq(8'hA0, 5, 4);
    drain();
    expQ.push_back({32'hA3A2A1A0, 1'b0, 4'b1011});
    expQ.push_back({32'h000000A4, 1'b1, 4'b0100});
    checks++;
    if (gotQ.size() != expQ.size()) begin
      failures++; $display("[TB] FAIL error_count got %0d beats expected %0d", gotQ.size(), expQ.size());
    end else begin
      for (int i = 0; i < expQ.size(); i++) begin
        checks++;
        if (gotQ[i] !== expQ[i]) begin
          failures++;
          $display("[TB] FAIL error_beat%0d got %h/%b/%b expected %h/%b/%b", i, gotQ[i].d, gotQ[i].l, gotQ[i].u, expQ[i].d, expQ[i].l, expQ[i].u);
        end
      end
    end
  endtask

  task automatic test_max_length();
    clearQueues();
    sendSeq(8'h10, 11, -1);
    sendSeq(8'h20, 3, -1);
    drain();
    expQ.push_back({32'h13121110, 1'b0, 4'b1011});
    expQ.push_back({32'h17161514, 1'b1, 4'b0111});
    expQ.push_back({32'h00222120, 1'b1, 4'b1010});
    checks++;
    if (gotMaxQ.size() != expQ.size()) begin
      failures++; $display("[TB] FAIL maxlen_count got %0d beats expected %0d", gotMaxQ.size(), expQ.size());
    end else begin
      for (int i = 0; i < expQ.size(); i++) begin
        checks++;
        if (gotMaxQ[i] !== expQ[i]) begin
          failures++;
          $display("[TB] FAIL maxlen_beat%0d got %h/%b/%b expected %h/%b/%b", i, gotMaxQ[i].d, gotMaxQ[i].l, gotMaxQ[i].u, expQ[i].d, expQ[i].l, expQ[i].u);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    clearQueues();
    sendByte(8'h5A, 1'b1, 1'b0);
    sendSeq(8'hC1, 3, -1);
    drain();
    expQ.push_back({32'h0000005A, 1'b1, 4'b1000});
    expQ.push_back({32'h00C3C2C1, 1'b1, 4'b1010});
    checks++;
    if (gotQ.size() != expQ.size()) begin
      failures++; $display("[TB] FAIL b2b_count got %0d beats expected %0d", gotQ.size(), expQ.size());
    end else begin
      for (int i = 0; i < expQ.size(); i++) begin
        checks++;
        if (gotQ[i] !== expQ[i]) begin
          failures++;
          $display("[TB] FAIL b2b_beat%0d got %h/%b/%b expected %h/%b/%b", i, gotQ[i].d, gotQ[i].l, gotQ[i].u, expQ[i].d, expQ[i].l, expQ[i].u);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    clearQueues();
    fifoReady = 1'b0;
    sendSeq(8'h11, 4, -1);
    macValid = 1'b1; macData = 8'h55; macLast = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (fifoValid !== 1'b1) begin failures++; $display("[TB] FAIL bp_tvalid got %b expected 1", fifoValid); end
    checks++; if (ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_tready got %b expected 0", ready); end
    checks++; if (fifoData !== 32'h14131211) begin failures++; $display("[TB] FAIL bp_tdata got %h expected 14131211", fifoData); end
    checks++; if (fifoUser !== 4'b1011) begin failures++; $display("[TB] FAIL bp_tuser got %b expected 1011", fifoUser); end
    @(posedge clk);
    #1;
    macValid = 1'b0; macLast = 1'b0;
    drain();
    checks++;
    if (gotQ.size() != 1) begin
      failures++; $display("[TB] FAIL bp_count got %0d beats expected 1", gotQ.size());
    end
  endtask

  task automatic test_random();
    logic [7:0]  b;
    logic [31:0] w;
    logic        u, errAcc;
    int          n, nFail;
    clearQueues();
    holdErrors = 0;
    randReady  = 1'b1;
    for (int f = 0; f < 100; f++) begin
      n = $urandom_range(1, 64);
      w = '0;
      errAcc = 1'b0;
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        u = ($urandom_range(0, 15) == 0);
        errAcc |= u;
        w[8*(i%4) +: 8] = b;
        if ((i % 4 == 3) || (i == n - 1)) begin
          expQ.push_back({w, i == n - 1, i < 4, errAcc, (i == n - 1) ? 2'(i % 4) : 2'b11});
          w = '0;
        end
        sendByte(b, i == n - 1, u);
      end
    end
    drain();
    checks++;
    if (gotQ.size() != expQ.size()) begin
      failures++; $display("[TB] FAIL random_count got %0d beats expected %0d", gotQ.size(), expQ.size());
    end else begin
      nFail = 0;
      for (int i = 0; i < expQ.size() && nFail < 10; i++) begin
        checks++;
        if (gotQ[i] !== expQ[i]) begin
          failures++; nFail++;
          $display("[TB] FAIL random_beat%0d got %h/%b/%b expected %h/%b/%b", i, gotQ[i].d, gotQ[i].l, gotQ[i].u, expQ[i].d, expQ[i].l, expQ[i].u);
        end
      end
    end
    checks++;
    if (holdErrors != 0) begin
      failures++; $display("[TB] FAIL random_hold_stable got %0d unstable held beats expected 0", holdErrors);
    end
  endtask

  task automatic test_reset_midframe();
    clearQueues();
    fifoReady = 1'b1;
    for (int i = 0; i < 6; i++) sendByte(8'h30 + 8'(i), 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (fifoValid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_tvalid got %b expected 0", fifoValid); end
    checks++; if (ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst_tready got %b expected 1", ready); end
    @(posedge clk);
    #1;
    sendSeq(8'h40, 4, -1);
    drain();
    expQ.push_back({32'h33323130, 1'b0, 4'b1011});
    expQ.push_back({32'h43424140, 1'b1, 4'b1011});
    checks++;
    if (gotQ.size() != expQ.size()) begin
      failures++; $display("[TB] FAIL midrst_count got %0d beats expected %0d", gotQ.size(), expQ.size());
    end else begin
      for (int i = 0; i < expQ.size(); i++) begin
        checks++;
        if (gotQ[i] !== expQ[i]) begin
          failures++;
          $display("[TB] FAIL midrst_beat%0d got %h/%b/%b expected %h/%b/%b", i, gotQ[i].d, gotQ[i].l, gotQ[i].u, expQ[i].d, expQ[i].l, expQ[i].u);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_max_length();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
